// File: rtl/bp_update_ctrl.sv
// Update scheduler and table-initialisation sequencer for the tournament predictor's write port.
// Buffers execute-stage resolutions in a small FIFO and sweeps table indices after reset/flush.
module bp_update_ctrl #(
   parameter int unsigned INDEX_BITS = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [31:0]           res_pc,
   input  logic                  res_taken,
   input  logic                  res_pred_taken,
   output logic                  tbl_we,
   input  logic                  tbl_ready,
   output logic                  tbl_init,
   output logic [INDEX_BITS-1:0] tbl_index,
   output logic [31:0]           tbl_pc,
   output logic                  tbl_taken,
   output logic                  pred_enable,
   output logic                  mispredict,
   output logic [31:0]           branch_cnt,
   output logic [31:0]           mispredict_cnt
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

   typedef enum logic {StSweep, StRun} state_e;

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
   logic [31:0]           pc_mem [FIFO_DEPTH];
   logic                  taken_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic                  mispredict_q;
   logic [31:0]           branch_cnt_q, mispredict_cnt_q;
   logic                  push, pop;

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      tbl_we      = 1'b0;
      tbl_init    = 1'b0;
      tbl_index   = '0;
      tbl_pc      = '0;
      tbl_taken   = 1'b0;
      res_ready   = 1'b0;
      pred_enable = 1'b0;
      unique case (state_q)
         StSweep: begin
            tbl_we    = 1'b1;
            tbl_init  = 1'b1;
            tbl_index = sweep_idx_q;
            if (tbl_ready) begin
               // Natural wrap returns the index to 0 as the sweep completes.
               sweep_idx_d = sweep_idx_q + 1'b1;
               if (sweep_idx_q == '1) state_d = StRun;
            end
         end
         StRun: begin
            pred_enable = 1'b1;
            res_ready   = (count_q < FULL_CNT) && !flush_req;
            tbl_we      = (count_q != '0);
            tbl_index   = pc_mem[rd_ptr_q][INDEX_BITS+1:2];
            tbl_pc      = pc_mem[rd_ptr_q];
            tbl_taken   = taken_mem[rd_ptr_q];
         end
      endcase
      if (flush_req) begin
         state_d     = StSweep;
         sweep_idx_d = '0;
      end
      if (rst) begin
         tbl_we    = 1'b0;
         res_ready = 1'b0;
      end
   end

   assign push = res_valid && res_ready;
   assign pop  = (state_q == StRun) && tbl_we && tbl_ready && !flush_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StSweep;
         sweep_idx_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         if (flush_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= res_pc;
         taken_mem[wr_ptr_q] <= res_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_q     <= 1'b0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         mispredict_q <= push && (res_taken != res_pred_taken);
         if (push) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if ((res_taken != res_pred_taken) && (mispredict_cnt_q != '1)) begin
               mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
         end
      end
   end

   assign mispredict     = mispredict_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomized self-checking bench for bp_update_ctrl against a queue-based reference model.
module tb_bp_update_ctrl;

   localparam int unsigned IB = 3;
   localparam int unsigned FD = 4;
   localparam int unsigned TBL_SIZE = 1 << IB;

   logic          clk = 1'b0;
   logic          rst, flush_req, res_valid, res_ready, res_taken, res_pred_taken;
   logic [31:0]   res_pc;
   logic          tbl_we, tbl_ready, tbl_init, tbl_taken, pred_enable, mispredict;
   logic [IB-1:0] tbl_index;
   logic [31:0]   tbl_pc, branch_cnt, mispredict_cnt;

   bp_update_ctrl #(.INDEX_BITS(IB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .flush_req(flush_req), .res_valid(res_valid),
      .res_ready(res_ready), .res_pc(res_pc), .res_taken(res_taken),
      .res_pred_taken(res_pred_taken), .tbl_we(tbl_we), .tbl_ready(tbl_ready),
      .tbl_init(tbl_init), .tbl_index(tbl_index), .tbl_pc(tbl_pc), .tbl_taken(tbl_taken),
      .pred_enable(pred_enable), .mispredict(mispredict), .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: sweeping flag + position, pending-update queue, statistics.
   bit          m_sweep = 1'b1;
   int          m_idx   = 0;
   logic [32:0] m_q[$];
   logic [31:0] m_bcnt  = '0;
   logic [31:0] m_mcnt  = '0;
   bit          m_pulse = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return !rst && !m_sweep && (m_q.size() < FD) && !flush_req;
   endfunction

   function automatic bit exp_we();
      return !rst && (m_sweep || (m_q.size() > 0));
   endfunction

   task automatic check_outputs();
      logic [31:0] hpc;
      if (rst) begin
         check_eq("we_in_rst", 32'(tbl_we), 32'd0);
         check_eq("ready_in_rst", 32'(res_ready), 32'd0);
         return;
      end
      check_eq("pred_enable", 32'(pred_enable), 32'(!m_sweep));
      check_eq("res_ready", 32'(res_ready), 32'(exp_ready()));
      check_eq("tbl_we", 32'(tbl_we), 32'(exp_we()));
      check_eq("mispredict", 32'(mispredict), 32'(m_pulse));
      check_eq("branch_cnt", branch_cnt, m_bcnt);
      check_eq("mispredict_cnt", mispredict_cnt, m_mcnt);
      if (m_sweep) begin
         check_eq("sweep_init", 32'(tbl_init), 32'd1);
         check_eq("sweep_index", 32'(tbl_index), 32'(m_idx));
         check_eq("sweep_pc", tbl_pc, 32'd0);
         check_eq("sweep_taken", 32'(tbl_taken), 32'd0);
      end else if (m_q.size() > 0) begin
         hpc = m_q[0][32:1];
         check_eq("upd_init", 32'(tbl_init), 32'd0);
         check_eq("upd_index", 32'(tbl_index), (hpc >> 2) % TBL_SIZE);
         check_eq("upd_pc", tbl_pc, hpc);
         check_eq("upd_taken", 32'(tbl_taken), 32'(m_q[0][0]));
      end
   endtask

   task automatic model_step();
      bit push, pop;
      if (rst) begin
         m_sweep = 1'b1; m_idx = 0; m_q.delete();
         m_bcnt = '0; m_mcnt = '0; m_pulse = 1'b0;
         return;
      end
      push = res_valid && exp_ready();
      pop  = exp_we() && tbl_ready;
      m_pulse = push && (res_taken != res_pred_taken);
      if (push) begin
         if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
         if (res_taken != res_pred_taken && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
      end
      if (flush_req) begin
         m_sweep = 1'b1; m_idx = 0; m_q.delete();
      end else if (m_sweep) begin
         if (pop) begin
            m_idx++;
            if (m_idx == TBL_SIZE) begin
               m_sweep = 1'b0; m_idx = 0;
            end
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back({res_pc, res_taken});
      end
   endtask

   // Apply inputs shortly after a rising edge, check mid-cycle, advance model at the edge.
   task automatic cycle(input logic r, input logic fl, input logic rv, input logic [31:0] pc,
                        input logic tk, input logic pt, input logic trdy);
      rst = r; flush_req = fl; res_valid = rv; res_pc = pc;
      res_taken = tk; res_pred_taken = pt; tbl_ready = trdy;
      #4;
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush_req = 1'b0; res_valid = 1'b0; res_pc = '0;
      res_taken = 1'b0; res_pred_taken = 1'b0; tbl_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset then an unstalled sweep of 8 writes.
      cycle(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 32'h40, 1, 1, 1);
      check_eq("pe_after_sweep", 32'(pred_enable), 32'd1);

      // First training update with a mispredict.
      cycle(0, 0, 1, 32'h0000_0010, 1, 0, 1);
      check_eq("first_upd_index", 32'(tbl_index), 32'd4);
      check_eq("first_upd_misp", 32'(mispredict), 32'd1);
      check_eq("first_upd_bcnt", branch_cnt, 32'd1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // Fill the FIFO under backpressure, then drain.
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h100 + 32'(i * 4), i[0], 0, 0);
      check_eq("full_ready", 32'(res_ready), 32'd0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 1);
      check_eq("drained_ready", 32'(res_ready), 32'd1);

      // Queue 3, flush with a valid resolution present, sweep with toggling ready.
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h200 + 32'(i * 4), 1, 1, 0);
      cycle(0, 1, 1, 32'h300, 1, 0, 1);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 0, (i % 2) == 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, $urandom, $urandom_range(1), 0, 1);

      // Reset in the middle of a sweep with nonzero counters.
      cycle(0, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0, 1);
      check_eq("rst_bcnt", branch_cnt, 32'd0);
      check_eq("rst_index", 32'(tbl_index), 32'd0);
      check_eq("rst_pe", 32'(pred_enable), 32'd0);

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(399) == 0, $urandom_range(59) == 0, $urandom_range(1),
               $urandom, $urandom_range(1), $urandom_range(1), $urandom_range(9) < 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
Update scheduler and table-initialisation sequencer for the tournament branch predictor's shared write port. It buffers branch resolutions from execute in a small FIFO and issues them to the predictor one per cycle under backpressure. It also sweeps every table index to its initial value after reset or flush, and keeps branch/mispredict statistics. It sits between the execute stage and the predictor's table write port.

Parameters:
INDEX_BITS, 8, predictor table index width; table holds 2^INDEX_BITS entries.
FIFO_DEPTH, 4, resolution FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_req  in  1  discard pending updates and re-initialise tables
res_valid  in  1  execute presents a resolved branch
res_ready  out  1  controller accepts the resolution this cycle
res_pc  in  32  PC of resolved branch
res_taken  in  1  actual outcome
res_pred_taken  in  1  prediction that was made for it
tbl_we  out  1  write request to predictor tables
tbl_ready  in  1  predictor accepts the write this cycle
tbl_init  out  1  1 = write initial values (sweep); 0 = training update
tbl_index  out  INDEX_BITS  table index
tbl_pc  out  32  PC for training update (0 during sweep)
tbl_taken  out  1  outcome for training update (0 during sweep)
pred_enable  out  1  predictions valid; fetch forces not-taken when 0
mispredict  out  1  one-cycle pulse, accepted resolution mismatched
branch_cnt  out  32  accepted resolutions, saturating
mispredict_cnt  out  32  accepted mispredictions, saturating

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values: state SWEEP, sweep_idx=0, FIFO empty, branch_cnt=0, mispredict_cnt=0, mispredict=0, pred_enable=0, res_ready=0. tbl_we is 0 in the cycle rst is high.
- States: SWEEP, RUN.
- SWEEP:
  - tbl_we=1, tbl_init=1, tbl_index=sweep_idx, tbl_pc=0, tbl_taken=0.
  - sweep_idx increments only on tbl_we&&tbl_ready.
  - When index 2^INDEX_BITS-1 is accepted, next state is RUN and sweep_idx wraps to 0.
  - res_ready=0 and pred_enable=0 throughout.
  - Minimum duration is 2^INDEX_BITS cycles.
- RUN:
  - pred_enable=1.
  - res_ready = (count < FIFO_DEPTH) && !flush_req.
  - Push on res_valid&&res_ready; entry stores {pc, taken}.
  - tbl_we = !empty, tbl_init=0, tbl_index = head.pc[INDEX_BITS+1:2], tbl_pc = head.pc, tbl_taken = head.taken.
  - Pop on tbl_we&&tbl_ready.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO is registered: an entry pushed in cycle t appears on tbl_* no earlier than t+1. No bypass.
  - Order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
- Statistics, on each push:
  - branch_cnt+1.
  - If res_taken!=res_pred_taken: mispredict_cnt+1, and mispredict=1 in the following cycle.
  - Both counters saturate at 0xFFFFFFFF.
  - Counters cleared only by rst, never by flush.
- flush_req (either state):
  - No push that cycle.
  - Next cycle: FIFO empty, sweep_idx=0, state SWEEP, pred_enable=0.
  - tbl_we in the flush cycle is still driven per the current state, but a pop/increment it causes is overridden by the flush.
  - flush_req held high keeps restarting the sweep at index 0.
- rst mid-sweep or mid-run: identical to power-on reset, including counter clear.
- tbl_ready=0: all outputs hold stable; no state change except pushes.

Test Plan:
- INDEX_BITS=3, rst 1 cycle, tbl_ready=1 -> 8 cycles of tbl_we=1, tbl_init=1, tbl_index 0..7; pred_enable=1 on the 9th cycle; res_ready=0 until then.
- After sweep, push pc=0x0000_0010 taken=1 pred=0 -> next cycle tbl_we=1, tbl_index=4, tbl_taken=1, mispredict pulse 1 cycle, branch_cnt=1, mispredict_cnt=1.
- tbl_ready=0, push 4 entries (FIFO_DEPTH=4) -> res_ready=0 after the 4th push. Raise tbl_ready -> entries leave in push order on 4 consecutive cycles, res_ready=1 again.
- Sweep with tbl_ready toggling 1,0,1,0 -> tbl_index advances only on ready cycles and holds otherwise; completes after 8 accepted writes.
- 3 entries queued, flush_req 1 cycle -> no further training writes; sweep restarts at index 0; counters unchanged; res_valid in the flush cycle not counted.
- rst asserted at sweep index 5 with counters nonzero -> sweep restarts at 0, counters=0, pred_enable=0.
